ysyx_24100029_lsu_axi_master: RTL

AXI4 initiator that turns the LSU's simple request/response memory port into single-beat AXI4 read and write transactions. It sits between the core's memory stage and the AXI crossbar, and drives slaves such as the CLINT, SRAM and UART. Exactly one transaction is outstanding at a time. Bus errors and ID mismatches are reported to the LSU.

---
 rtl/ysyx_24100029_lsu_axi_master_if.sv | 68 ++++++
 rtl/ysyx_24100029_lsu_axi_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_lsu_axi_master_if.sv
// Bundle of the LSU request/response port and the five AXI4 channels.
// The master modport is the initiator's view and the slave modport is the memory side's view.
interface ysyx_24100029_lsu_axi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic [3:0]  rid;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        wlast;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;

    modport master (
        input  req_valid, req_wen, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
        input  arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        output wdata, wstrb, wvalid, wlast, bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_size, req_wdata, req_wstrb, rsp_ready,
        output arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        input  wdata, wstrb, wvalid, wlast, bready
    );
endinterface

// File: rtl/ysyx_24100029_lsu_axi_master.sv
// LSU-to-AXI4 initiator: one single-beat read or write outstanding at a time.
// Every bus-facing output comes straight from a flop.
module ysyx_24100029_lsu_axi_master #(
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic                                  i_clock,
    input  logic                                  i_rst_n,
    ysyx_24100029_lsu_axi_master_if.master        io_bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic        r_req_ready, w_req_ready_nxt;
    logic [31:0] r_addr,      w_addr_nxt;
    logic [2:0]  r_size,      w_size_nxt;
    logic [31:0] r_wdata,     w_wdata_nxt;
    logic [3:0]  r_wstrb,     w_wstrb_nxt;
    logic        r_arvalid,   w_arvalid_nxt;
    logic        r_rready,    w_rready_nxt;
    logic        r_awvalid,   w_awvalid_nxt;
    logic        r_wvalid,    w_wvalid_nxt;
    logic        r_bready,    w_bready_nxt;
    logic        r_aw_done,   w_aw_done_nxt;
    logic        r_w_done,    w_w_done_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_rsp_err,   w_rsp_err_nxt;

    logic        w_req_hs;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused_rlast;

    // A response is bad if the slave flagged an error or it answered with someone else's ID.
    function automatic logic f_rsp_bad(input logic [1:0] resp, input logic [3:0] id);
        return (resp != 2'b00) || (id != AXI_ID);
    endfunction

    assign w_req_hs       = io_bus.req_valid && r_req_ready;
    assign w_aw_hs        = r_awvalid && io_bus.awready;
    assign w_w_hs         = r_wvalid && io_bus.wready;
    assign w_unused_rlast = io_bus.rlast;

    // Next-state and next-output decode; everything holds unless a case below changes it.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_addr_nxt      = r_addr;
        w_size_nxt      = r_size;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) begin
                    w_req_ready_nxt = 1'b0;
                    w_addr_nxt      = io_bus.req_addr;
                    w_size_nxt      = io_bus.req_size;
                    w_wdata_nxt     = io_bus.req_wdata;
                    w_wstrb_nxt     = io_bus.req_wstrb;
                    w_aw_done_nxt   = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    if (io_bus.req_wen) begin
                        w_state_nxt   = ST_AW_W;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_AR;
                        w_arvalid_nxt = 1'b1;
                        w_rready_nxt  = 1'b1;
                    end
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end

            // rvalid before the address is accepted belongs to nobody and is dropped.
            ST_AR: begin
                if (io_bus.arready) begin
                    w_arvalid_nxt = 1'b0;
                    if (io_bus.rvalid) begin
                        w_state_nxt     = ST_RSP;
                        w_rready_nxt    = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = io_bus.rdata;
                        w_rsp_err_nxt   = f_rsp_bad(io_bus.rresp, io_bus.rid);
                    end else begin
                        w_state_nxt = ST_R;
                    end
                end else begin
                    w_state_nxt = ST_AR;
                end
            end

            ST_R: begin
                if (io_bus.rvalid) begin
                    w_state_nxt     = ST_RSP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = io_bus.rdata;
                    w_rsp_err_nxt   = f_rsp_bad(io_bus.rresp, io_bus.rid);
                end else begin
                    w_state_nxt = ST_R;
                end
            end

            // AW and W complete independently; B waits until both have gone.
            ST_AW_W: begin
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                w_awvalid_nxt = r_awvalid & ~w_aw_hs;
                w_wvalid_nxt  = r_wvalid & ~w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt  = ST_B;
                    w_bready_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_AW_W;
                end
            end

            ST_B: begin
                if (io_bus.bvalid) begin
                    w_state_nxt     = ST_RSP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'h0000_0000;
                    w_rsp_err_nxt   = f_rsp_bad(io_bus.bresp, io_bus.bid);
                end else begin
                    w_state_nxt = ST_B;
                end
            end

            ST_RSP: begin
                if (io_bus.rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RSP;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_bready_nxt    = 1'b0;
                w_aw_done_nxt   = 1'b0;
                w_w_done_nxt    = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_addr      <= 32'h0000_0000;
            r_size      <= 3'd0;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'h0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_addr      <= w_addr_nxt;
            r_size      <= w_size_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign io_bus.req_ready = r_req_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rsp_rdata;
    assign io_bus.rsp_err   = r_rsp_err;

    assign io_bus.araddr  = r_addr;
    assign io_bus.arvalid = r_arvalid;
    assign io_bus.arid    = AXI_ID;
    assign io_bus.arlen   = 8'd0;
    assign io_bus.arsize  = r_size;
    assign io_bus.arburst = 2'b01;
    assign io_bus.rready  = r_rready;

    assign io_bus.awaddr  = r_addr;
    assign io_bus.awvalid = r_awvalid;
    assign io_bus.awid    = AXI_ID;
    assign io_bus.awlen   = 8'd0;
    assign io_bus.awsize  = r_size;
    assign io_bus.awburst = 2'b01;

    assign io_bus.wdata  = r_wdata;
    assign io_bus.wstrb  = r_wstrb;
    assign io_bus.wvalid = r_wvalid;
    assign io_bus.wlast  = 1'b1;
    assign io_bus.bready = r_bready;

endmodule
